// File: rtl/fl_checkpoint_ctrl.sv
// rtl/fl_checkpoint_ctrl.sv - branch checkpoints of the speculative free-list head
// Optional: FL_CKPT_STALL_CNT_EN adds fullStallCnt_o (saturating full-stall cycle count).
module fl_checkpoint_ctrl #(
  parameter int NUM_CKPT = 8,
  parameter int CKPT_LOG = 3,
  parameter int FL_LOG   = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                recoverFlag_i,
  input  logic                stall_i,
  input  logic                alloc_i,
  input  logic [FL_LOG-1:0]   freeListHead_i,
  output logic                allocGrant_o,
  output logic [CKPT_LOG-1:0] allocTag_o,
  output logic                ckptFull_o,
  input  logic                resolve_i,
  input  logic [CKPT_LOG-1:0] resolveTag_i,
  input  logic                mispredict_i,
  output logic [FL_LOG-1:0]   freeListHeadCp_o,
  output logic                ctrlVerified_o,
  output logic                flagRecoverEX_o,
`ifdef FL_CKPT_STALL_CNT_EN
  output logic [15:0]         fullStallCnt_o,
`endif
  output logic                tagErr_o
);

  logic [CKPT_LOG:0]   head_q, head_d, tail_q, tail_d, count;
  logic [NUM_CKPT-1:0] valid_q, valid_d;
  logic [FL_LOG-1:0]   head_mem_q [NUM_CKPT];
  logic [FL_LOG-1:0]   head_cp_q, head_cp_d;
  logic                verified_q, verified_d;
  logic                recover_ex_q, recover_ex_d;
  logic                tag_err_q, tag_err_d;
  logic                res_valid, res_ok, mis_ok;
  logic [CKPT_LOG-1:0] tag_off, slot_off;

  assign count      = tail_q - head_q;
  assign ckptFull_o = (count == (CKPT_LOG+1)'(NUM_CKPT));
  assign res_valid  = valid_q[resolveTag_i];
  assign res_ok     = resolve_i & res_valid & ~recoverFlag_i;
  assign mis_ok     = res_ok & mispredict_i;
  assign allocTag_o = tail_q[CKPT_LOG-1:0];
  assign allocGrant_o = alloc_i & ~stall_i & ~ckptFull_o & ~recoverFlag_i
                      & ~(resolve_i & mispredict_i & res_valid);
  // Age of the resolved slot relative to the oldest live checkpoint.
  assign tag_off    = resolveTag_i - head_q[CKPT_LOG-1:0];

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    valid_d      = valid_q;
    head_cp_d    = head_cp_q;
    verified_d   = 1'b0;
    recover_ex_d = 1'b0;
    tag_err_d    = tag_err_q;
    slot_off     = '0;
    if (recoverFlag_i) begin
      valid_d = '0;
      head_d  = tail_q;
    end else begin
      verified_d   = res_ok;
      recover_ex_d = mis_ok;
      if (resolve_i && !res_valid) tag_err_d = 1'b1;
      if (mis_ok) begin
        head_cp_d = head_mem_q[resolveTag_i];
        for (int i = 0; i < NUM_CKPT; i++) begin
          slot_off = CKPT_LOG'(i) - head_q[CKPT_LOG-1:0];
          if (slot_off >= tag_off) valid_d[i] = 1'b0;
        end
        tail_d = head_q + {1'b0, tag_off};
      end else begin
        if (res_ok) valid_d[resolveTag_i] = 1'b0;
        if (allocGrant_o) begin
          valid_d[tail_q[CKPT_LOG-1:0]] = 1'b1;
          tail_d = tail_q + 1'b1;
        end
      end
      // A live head slot is never behind a mispredict cut, so retiring here cannot pass tail.
      if (count != '0 && !valid_q[head_q[CKPT_LOG-1:0]]) head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      head_cp_q    <= '0;
      verified_q   <= 1'b0;
      recover_ex_q <= 1'b0;
      tag_err_q    <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      valid_q      <= valid_d;
      head_cp_q    <= head_cp_d;
      verified_q   <= verified_d;
      recover_ex_q <= recover_ex_d;
      tag_err_q    <= tag_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && allocGrant_o) head_mem_q[tail_q[CKPT_LOG-1:0]] <= freeListHead_i;
  end

  assign freeListHeadCp_o = head_cp_q;
  assign ctrlVerified_o   = verified_q;
  assign flagRecoverEX_o  = recover_ex_q;
  assign tagErr_o         = tag_err_q;

`ifdef FL_CKPT_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (alloc_i && !stall_i && ckptFull_o && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
  assign fullStallCnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/fl_checkpoint_ctrl.md
# fl_checkpoint_ctrl

Manages branch checkpoints of the speculative free-list head for the rename stage. Each branch leaving rename gets a checkpoint slot holding the free-list head, tagged in-order. Branch resolution either releases the slot or, on mispredict, drives the saved head plus the recovery strobes into the speculative free list and squashes all younger slots. It sits between rename/dispatch, the execute-stage branch resolution bus and the speculative free list.

## Interface
- NUM_CKPT, 8, number of checkpoint slots (power of two)
- CKPT_LOG, 3, log2(NUM_CKPT)
- FL_LOG, 7, free-list index width (equals `SIZE_FREE_LIST_LOG)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- recoverFlag_i  in  1  full pipeline flush from commit
- stall_i  in  1  rename stall; blocks allocation
- alloc_i  in  1  a branch in the current rename group needs a checkpoint
- freeListHead_i  in  FL_LOG  free-list head to snapshot for that branch
- allocGrant_o  out  1  checkpoint allocated this cycle (combinational)
- allocTag_o  out  CKPT_LOG  tag of allocated slot (= tail, combinational)
- ckptFull_o  out  1  all slots valid (combinational from state)
- resolve_i  in  1  branch resolution valid
- resolveTag_i  in  CKPT_LOG  tag being resolved
- mispredict_i  in  1  resolution is a mispredict
- freeListHeadCp_o  out  FL_LOG  registered saved head, to free list
- ctrlVerified_o  out  1  registered one-cycle strobe of any accepted resolution
- flagRecoverEX_o  out  1  registered one-cycle strobe of accepted mispredict
- tagErr_o  out  1  sticky: resolution seen for a non-valid tag

## Operation
- State: head, tail (CKPT_LOG+1 bits, MSB wrap), valid[NUM_CKPT], headMem[NUM_CKPT] of FL_LOG.
- count = tail - head; ckptFull_o = (count == NUM_CKPT).
- Priority per cycle: reset > recoverFlag_i > accepted mispredict > allocation/release.
- Allocation: allocGrant_o = alloc_i & ~stall_i & ~ckptFull_o & ~recoverFlag_i & ~(resolve_i & mispredict_i & valid[resolveTag_i]). On grant: headMem[tail]<=freeListHead_i, valid[tail]<=1, tail<=tail+1.
- Resolution accepted only if valid[resolveTag_i]; otherwise ignored, tagErr_o<=1.
- Correct prediction: valid[tag]<=0; no other state change.
- Mispredict: freeListHeadCp_o<=headMem[tag]; clear valid for tag and every younger slot (tag through tail-1, modular); tail<=tag position (same wrap bit as the slot's age).
- Retirement: each cycle, if count>0 and valid[head]==0, head<=head+1 (at most one per cycle). Never passes tail.
- recoverFlag_i: all valid<=0, head<=tail, strobes 0.
- reset: head=tail=0, valid all 0, freeListHeadCp_o=0, ctrlVerified_o=0, flagRecoverEX_o=0, tagErr_o=0; allocGrant_o=0 and ckptFull_o=0 follow.

## Timing
- Allocation: grant/tag same cycle as alloc_i; slot visible next cycle.
- Resolution to free list: exactly 1 cycle (registered strobes and head); strobes high for one cycle only.
- Mispredict and alloc same cycle: alloc dropped, allocGrant_o=0; rename must retry.
- Slot freed by correct resolution is reusable only after head advances past it (≥1 cycle).
- Full: alloc_i held with allocGrant_o=0 until a slot retires; no state corruption.
- Wrap: tag wraps NUM_CKPT-1 -> 0; MSB of head/tail distinguishes full from empty.

## Configuration
- FL_CKPT_STALL_CNT_EN defined: adds output fullStallCnt_o (16 bits), saturating count of cycles with alloc_i & ~stall_i & ckptFull_o; cleared by reset only.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, alloc 3 branches with heads 5,9,12 -> tags 0,1,2, count 3, ckptFull_o=0.
- Mispredict tag 1 -> next cycle freeListHeadCp_o=9, ctrlVerified_o=1, flagRecoverEX_o=1; tail=1, tag 2 invalid; next alloc gets tag 1.
- Fill 8 slots, alloc again -> allocGrant_o=0, ckptFull_o=1; correct-resolve tag 0 -> head advances, grant next cycle with tag 0 (wrap).
- Correct-resolve tag 3 out of order then tag 0 -> head stays until tag 0 cleared, then advances one per cycle.
- Same-cycle alloc and mispredict tag 0 -> alloc dropped, tail=0, flagRecoverEX_o=1 next cycle.
- Resolve invalid tag 6 -> no strobe, tagErr_o=1 sticky; recoverFlag_i mid-operation -> count 0, no strobes.
